// File: rtl/sys_arr_pkg.sv
// sys_arr_pkg: shared FSM state type and geometry helpers for the output-stationary array
package sys_arr_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;
  function automatic int kw(input int kmax);
    return $clog2(kmax + 1);
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int flush_cyc(input int rows, input int cols);
    return rows + cols - 2;
  endfunction
endpackage

// File: rtl/sys_pe.sv
// sys_pe: one output-stationary MAC cell with operand pass registers and a clearable accumulator
module sys_pe #(
  parameter int DW   = 8,
  parameter int ACCW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  input  logic            sgn,
  input  logic [DW-1:0]   a_in,
  input  logic            a_vin,
  input  logic [DW-1:0]   w_in,
  input  logic            w_vin,
  output logic [DW-1:0]   a_out,
  output logic            a_vout,
  output logic [DW-1:0]   w_out,
  output logic            w_vout,
  output logic [ACCW-1:0] acc_d
);
  logic [ACCW-1:0] acc;
  logic signed [2*DW-1:0] ps;
  logic [2*DW-1:0] pu;
  logic [ACCW-1:0] prod;
  always_comb begin
    ps    = $signed({{DW{a_in[DW-1]}}, a_in}) * $signed({{DW{w_in[DW-1]}}, w_in});
    pu    = {{DW{1'b0}}, a_in} * {{DW{1'b0}}, w_in};
    prod  = sgn ? ACCW'(ps) : ACCW'(pu);
    acc_d = clr ? '0 : (en && a_vin && w_vin) ? acc + prod : acc;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      a_out  <= '0;
      a_vout <= 1'b0;
      w_out  <= '0;
      w_vout <= 1'b0;
    end else begin
      acc <= acc_d;
      if (en) begin
        a_out  <= a_in;
        a_vout <= a_vin;
        w_out  <= w_in;
        w_vout <= w_vin;
      end
    end
  end
endmodule

// File: rtl/sys_array_os.sv
// sys_array_os: output-stationary systolic MAC array with input skew, run control and row drain
module sys_array_os import sys_arr_pkg::*; #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int DW   = 8,
  parameter int ACCW = 32,
  parameter int KMAX = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [kw(KMAX)-1:0]      k_len,
  input  logic                     acc_mode,
  input  logic                     signed_mode,
  output logic                     busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROWS*DW-1:0]       in_a,
  input  logic [COLS*DW-1:0]       in_w,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COLS*ACCW-1:0]     out_data,
  output logic [idx_w(ROWS)-1:0]   out_row,
  output logic                     out_last,
  output logic                     done
);
  localparam int KW = kw(KMAX);
  localparam int RW = idx_w(ROWS);
  localparam int FC = flush_cyc(ROWS, COLS);
  localparam int FW = $clog2(ROWS + COLS);
  state_t state, nxt;
  logic [KW-1:0] klen, kc;
  logic [FW-1:0] fc;
  logic [RW-1:0] orow, sel;
  logic sgn, inj_v, adv, clr, last, load;
  logic [COLS*ACCW-1:0] drow;
  logic [DW-1:0] a_h [ROWS][COLS+1];
  logic          av_h [ROWS][COLS+1];
  logic [DW-1:0] w_h [ROWS+1][COLS];
  logic          wv_h [ROWS+1][COLS];
  logic [ACCW-1:0] acc_d [ROWS][COLS];
  assign inj_v     = state == STREAM && in_valid;
  assign adv       = inj_v || state == FLUSH;
  assign clr       = state == IDLE && start && !acc_mode;
  assign last      = orow == RW'(ROWS - 1);
  assign busy      = state != IDLE;
  assign in_ready  = state == STREAM;
  assign out_valid = state == DRAIN;
  assign out_last  = state == DRAIN && last;
  assign out_row   = orow;
  assign load      = (state != DRAIN && nxt == DRAIN) || (state == DRAIN && out_ready && !last);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (start) nxt = k_len == '0 ? DRAIN : STREAM;
      STREAM: if (inj_v && kc == klen - KW'(1)) nxt = FC == 0 ? DRAIN : FLUSH;
      FLUSH:  if (fc == FW'(FC - 1)) nxt = DRAIN;
      DRAIN:  if (out_ready && last) nxt = IDLE;
    endcase
  end
  // The drain register samples next-state accumulators so the row loaded on DRAIN entry already includes the final edge's update or clear
  always_comb begin
    sel  = state == DRAIN ? orow + RW'(1) : '0;
    drow = '0;
    for (int c = 0; c < COLS; c++) drow[c*ACCW +: ACCW] = acc_d[sel][c];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      klen     <= '0;
      kc       <= '0;
      fc       <= '0;
      sgn      <= 1'b0;
      orow     <= '0;
      done     <= 1'b0;
      out_data <= '0;
    end else begin
      state <= nxt;
      done  <= state == DRAIN && out_ready && last;
      fc    <= state == FLUSH ? fc + FW'(1) : '0;
      if (state == IDLE && start) begin
        klen <= k_len;
        sgn  <= signed_mode;
        kc   <= '0;
      end else if (inj_v) kc <= kc + KW'(1);
      if (state == DRAIN && out_ready) orow <= last ? '0 : orow + RW'(1);
      if (load) out_data <= drow;
    end
  end
  // Row r activations and column c weights are delayed r (resp. c) advances before entering the grid
  for (genvar r = 0; r < ROWS; r++) begin : g_ra
    if (r == 0) begin : g_z
      assign a_h[0][0]  = in_a[0 +: DW];
      assign av_h[0][0] = inj_v;
    end else begin : g_d
      logic [DW-1:0] d [r];
      logic          dv [r];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < r; s++) begin
            d[s]  <= '0;
            dv[s] <= 1'b0;
          end
        end else if (adv) begin
          d[0]  <= in_a[r*DW +: DW];
          dv[0] <= inj_v;
          for (int s = 1; s < r; s++) begin
            d[s]  <= d[s-1];
            dv[s] <= dv[s-1];
          end
        end
      end
      assign a_h[r][0]  = d[r-1];
      assign av_h[r][0] = dv[r-1];
    end
  end
  for (genvar c = 0; c < COLS; c++) begin : g_wa
    if (c == 0) begin : g_z
      assign w_h[0][0]  = in_w[0 +: DW];
      assign wv_h[0][0] = inj_v;
    end else begin : g_d
      logic [DW-1:0] d [c];
      logic          dv [c];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < c; s++) begin
            d[s]  <= '0;
            dv[s] <= 1'b0;
          end
        end else if (adv) begin
          d[0]  <= in_w[c*DW +: DW];
          dv[0] <= inj_v;
          for (int s = 1; s < c; s++) begin
            d[s]  <= d[s-1];
            dv[s] <= dv[s-1];
          end
        end
      end
      assign w_h[0][c]  = d[c-1];
      assign wv_h[0][c] = dv[c-1];
    end
  end
  for (genvar r = 0; r < ROWS; r++) begin : g_r
    for (genvar c = 0; c < COLS; c++) begin : g_c
      sys_pe #(.DW(DW), .ACCW(ACCW)) u_pe (
        .clk    (clk),
        .rst    (rst),
        .en     (adv),
        .clr    (clr),
        .sgn    (sgn),
        .a_in   (a_h[r][c]),
        .a_vin  (av_h[r][c]),
        .w_in   (w_h[r][c]),
        .w_vin  (wv_h[r][c]),
        .a_out  (a_h[r][c+1]),
        .a_vout (av_h[r][c+1]),
        .w_out  (w_h[r+1][c]),
        .w_vout (wv_h[r+1][c]),
        .acc_d  (acc_d[r][c])
      );
    end
  end
endmodule

// File: doc/sys_array_os.md
Name: sys_array_os

Overview:
- Parametrised output-stationary systolic MAC array; next generation of the PE array.
- Adds internal input skewing, a valid/ready streaming input, run control (start/k_len/done), accumulate-or-clear mode, signed/unsigned mode, and a back-pressured row-by-row result drain.
- Sits between the operand buffers (activation rows, weight columns) and the result writeback path.

Parameters:
ROWS, 8, PE rows (activation lanes)
COLS, 8, PE columns (weight lanes)
DW, 8, operand width
ACCW, 32, accumulator width (must be >= 2*DW)
KMAX, 256, maximum reduction length; KW = $clog2(KMAX+1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  run request, sampled in IDLE only
k_len  in  KW  beats in the run, latched on start
acc_mode  in  1  1 = accumulate onto existing results; 0 = clear accumulators at start
signed_mode  in  1  1 = signed operands; latched on start
busy  out  1  high whenever state != IDLE
in_valid  in  1  operand beat valid
in_ready  out  1  high only in STREAM
in_a  in  ROWS*DW  activations, lane r at [r*DW +: DW]
in_w  in  COLS*DW  weights, lane c at [c*DW +: DW]
out_valid  out  1  result row valid
out_ready  in  1  downstream accepts the row
out_data  out  COLS*ACCW  accumulators of row out_row, column c at [c*ACCW +: ACCW]
out_row  out  $clog2(ROWS)  row index of out_data
out_last  out  1  high with the final row (ROWS-1)
done  out  1  one-cycle pulse after the final drain handshake

Behaviour:
- Reset (async): state IDLE; all accumulators, skew registers and counters 0; busy, in_ready, out_valid, out_last and done 0; out_data 0; out_row 0.
- FSM: IDLE -> STREAM -> FLUSH -> DRAIN -> IDLE.
- IDLE, start=1: latch k_len and signed_mode. If acc_mode=0, clear all accumulators on the same edge.
  - k_len=0: go directly to DRAIN.
  - Otherwise: go to STREAM.
- start outside IDLE is ignored.
- STREAM: in_ready=1. Each in_valid&in_ready edge is an advance edge: push the beat into the skew lines and increment the beat counter.
  - No accepted beat means no advance: the whole array and the skew lines hold (bubble-free stall).
  - After beat k_len is accepted, go to FLUSH.
- Skew: row r activation is delayed r advances; column c weight is delayed c advances (row 0 and column 0 have zero delay).
  - A valid bit travels with each operand.
  - Activations pass right one PE per advance; weights pass down one PE per advance.
- PE(r,c) adds a[k][r]*w[k][c] on the (r+c)-th advance edge after the edge that accepted beat k (0 = same edge). It accumulates only when both of its operands are valid.
- FLUSH: advances every cycle with invalid operands injected, for ROWS+COLS-2 cycles (0 cycles if ROWS+COLS=2), then go to DRAIN.
- Arithmetic:
  - Product is 2*DW bits, sign- or zero-extended per signed_mode to ACCW.
  - Accumulation wraps modulo 2^ACCW; no saturation, no flag.
- DRAIN:
  - out_valid=1 and out_row starts at 0.
  - out_data is a registered copy of row out_row. It holds stable while out_valid&!out_ready.
  - Each handshake increments out_row; out_last=1 when out_row=ROWS-1.
  - The handshake on the last row leads to IDLE with done=1 for one cycle. The out_valid/out_ready/out_row/out_last drain outputs return to 0; out_data may retain its last value.
- Accumulators retain their values after DRAIN (this is what acc_mode=1 relies on).
- rst mid-run (any state): immediate abort to reset values. Partial sums are discarded and no done is produced.
- busy falls in the same cycle done pulses.

Decomposition:
- sys_arr_pkg:
  - state enum (IDLE, STREAM, FLUSH, DRAIN)
  - width helpers (KW, row-index width)
  - localparam FLUSH_CYC = ROWS+COLS-2
- Sub-module sys_pe: one PE containing the operand pass registers, valid bits, the signed/unsigned MAC, an accumulator with clear, and the advance enable.
- The top module owns the FSM, counters, skew shift lines, the generate grid, and the drain mux/register.

Test Plan:
- acc_mode=0, signed_mode=0, k_len=10, w lanes=1, beat k a lanes=k+1 (1..10), in_valid held high -> 8 drain beats, every accumulator =55, out_last on row 7, one done pulse.
- Repeat the same run with acc_mode=1 -> every accumulator =110; then acc_mode=0, k_len=1, a=3, w=4 -> all =12.
- in_valid toggled 1/0 every cycle during a k_len=10 run (same data as the first scenario) -> results still 55; in_ready high only in STREAM.
- out_ready low for 5 cycles while out_row=3 -> out_data/out_row stable, no skipped or duplicated rows, done only after the row-7 handshake.
- signed_mode=1, a=0xFF, w=0x02, k_len=4 -> all =0xFFFFFFF8; same stimulus with signed_mode=0 -> all =2040.
- rst pulsed mid-FLUSH -> busy/out_valid/done 0 immediately, accumulators 0. Then k_len=0 with acc_mode=1 -> immediate DRAIN of all zeros. start while busy -> ignored.
